sram_rr_arbiter: RTL and testbench
==================================

// Module: sram_rr_arbiter
// PURPOSE
//  Shares one single-port SRAM (1-cycle registered read, read_en/write_en/addr/data_in/data_out)
//  between NUM_REQ requesters. Each requester issues read or write beats over valid/ready.
//  Round-robin among requesters, with burst locking bounded by MAX_BURST.
//  Sits between PE/buffer loaders and each activation/weight SRAM bank.
// PARAMETERS
//  NUM_REQ         4    number of requesters (>=2)
//  SRAM_DEPTH_BIT  10   SRAM address width
//  SRAM_WIDTH      64   SRAM data width
//  MAX_BURST       16   max consecutive beats one requester may hold the lock
// PORTS
//  clk            in   1                     clock, rising edge
//  rst            in   1                     synchronous reset, active-high
//  req_valid      in   NUM_REQ               beat request per requester
//  req_ready      out  NUM_REQ               beat accepted (combinational grant)
//  req_we         in   NUM_REQ               1=write beat, 0=read beat
//  req_last       in   NUM_REQ               last beat of burst; releases the lock
//  req_addr       in   NUM_REQ*SRAM_DEPTH_BIT packed, requester i at [i*AW +: AW]
//  req_wdata      in   NUM_REQ*SRAM_WIDTH    packed, requester i at [i*DW +: DW]
//  rsp_valid      out  NUM_REQ               read data valid for requester i
//  rsp_data       out  SRAM_WIDTH            read data, shared by all requesters
//  sram_read_en   out  1                     to SRAM read_en
//  sram_write_en  out  1                     to SRAM write_en
//  sram_addr      out  SRAM_DEPTH_BIT        to SRAM addr
//  sram_data_in   out  SRAM_WIDTH            to SRAM data_in
//  sram_data_out  in   SRAM_WIDTH            from SRAM data_out
// BEHAVIOUR
//  - Reset: state=IDLE, rr_ptr=0, beat_cnt=0, rsp_valid=0, rsp_id=0. Combinational outputs are 0 while rst=1.
//  - At most one req_ready bit is high per cycle. A beat transfers when req_valid[i] & req_ready[i].
//  - IDLE: grant the first valid requester at or after rr_ptr, searching with wrap.
//      Transfer with req_last=1: stay IDLE, rr_ptr <= g+1 (mod NUM_REQ).
//      Transfer with req_last=0: go to LOCK(owner=g), beat_cnt <= 1.
//  - LOCK: req_ready = req_valid[owner] only; other requesters wait.
//      Owner idle cycles (valid=0) keep the lock and do not count as beats.
//      Each owner beat increments beat_cnt.
//      Exit to IDLE with rr_ptr <= owner+1 when the owner transfers with req_last=1,
//      or when beat_cnt reaches MAX_BURST (forced release, remainder re-arbitrates).
//  - SRAM drive, same cycle as the granted transfer:
//      sram_write_en = xfer & we;  sram_read_en = xfer & ~we;
//      sram_addr and sram_data_in come from the granted requester.
//      With no transfer, enables are 0 and addr/data are don't-care (driven 0).
//  - Read latency is exactly 1 cycle after the accepted read beat:
//      rsp_valid[rsp_id] = 1 and rsp_data = sram_data_out.
//      A read response has no backpressure; the requester must accept it.
//  - Back-to-back beats reach full throughput: one beat per cycle, and reads may issue every cycle.
//  - A write followed by a read to the same address in the next cycle returns the new data,
//      because the SRAM write is committed at the edge before the read.
//  - Reset asserted mid-burst: the lock is dropped and any in-flight read response is suppressed
//      (rsp_valid=0 in the cycle after rst).
// STRUCTURE
//  - Shared package (sram_arb_pkg): state enum {IDLE, LOCK} and a function clog2 for ID widths.
//  - One sub-module: rr_pick (combinational round-robin find-first-from-pointer, NUM_REQ wide).
//  - Top level holds the FSM, owner, rr_ptr, beat_cnt, rsp_id/rsp_pend and the SRAM mux.
//  - The bench pairs this block with the behavioural SRAM model (depth 2**SRAM_DEPTH_BIT).
// TESTING
//  1. Requesters 0..3 each issue a single read (last=1) continuously from reset.
//     -> grants cycle 0,1,2,3,0..., one per cycle; rsp_valid one-hot lags the grant by 1 cycle.
//  2. Req1 writes 0xA5A5 to addr 5, then reads addr 5 in the next cycle.
//     -> rsp_valid[1] 2 cycles after the write, rsp_data=0xA5A5.
//  3. Req2 issues a 4-beat read burst (last on beat 4) while req0 is valid.
//     -> req0 is blocked for 4 beats, then granted; rr_ptr=3 after the burst.
//  4. Req3 issues a 40-beat burst with MAX_BURST=16.
//     -> forced release after beat 16; other valid requesters get one grant each before req3 resumes.
//  5. rst pulsed for 1 cycle in LOCK with a read in flight.
//     -> rsp_valid=0 the next cycle; state IDLE; first post-reset grant goes to the lowest valid index.
//  6. Random mixed traffic against a scoreboard memory model.
//     -> every read matches the model; no two enables in the same cycle; no requester waits
//        longer than (NUM_REQ-1)*MAX_BURST cycles.

Source files
------------

// File: rtl/sram_rr_arbiter_pkg.sv
// sram_arb_pkg: shared FSM state type and width helper for the SRAM round-robin arbiter
package sram_arb_pkg;
  typedef enum logic {IDLE, LOCK} arb_state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction
endpackage

// File: rtl/sram_rr_arbiter_rr_pick.sv
// rr_pick: combinational find-first set request at or after ptr, wrapping; req in, one-hot gnt and index id out
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] id
);
  always_comb begin
    gnt = '0;
    id  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt = N'(1) << ((int'(ptr) + k) % N);
        id  = IW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter: round-robin share of one 1-cycle-read SRAM with MAX_BURST-bounded burst lock; req_* beats in, sram_* drive out, rsp_* read return
module sram_rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int SRAM_DEPTH_BIT = 10,
  parameter int SRAM_WIDTH     = 64,
  parameter int MAX_BURST      = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ-1:0]                 req_we,
  input  logic [NUM_REQ-1:0]                 req_last,
  input  logic [NUM_REQ*SRAM_DEPTH_BIT-1:0]  req_addr,
  input  logic [NUM_REQ*SRAM_WIDTH-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic [SRAM_WIDTH-1:0]              rsp_data,
  output logic                               sram_read_en,
  output logic                               sram_write_en,
  output logic [SRAM_DEPTH_BIT-1:0]          sram_addr,
  output logic [SRAM_WIDTH-1:0]              sram_data_in,
  input  logic [SRAM_WIDTH-1:0]              sram_data_out
);
  localparam int IW = clog2(NUM_REQ);
  localparam int CW = clog2(MAX_BURST + 1);
  arb_state_e state, state_nxt;
  logic [IW-1:0] owner, owner_nxt, rr_ptr, ptr_nxt, ptr_inc, pick_id, gid, rsp_id;
  logic [CW-1:0] beat_cnt, cnt_nxt, cnt_inc;
  logic [NUM_REQ-1:0] pick_gnt;
  logic xfer, we, last, rel, rsp_pend;
  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req(req_valid),
    .ptr(rr_ptr),
    .gnt(pick_gnt),
    .id(pick_id)
  );
  always_comb begin
    gid           = state == LOCK ? owner : pick_id;
    req_ready     = rst ? '0 : state == LOCK ? NUM_REQ'(req_valid[owner]) << owner : pick_gnt;
    xfer          = |(req_valid & req_ready);
    we            = req_we[gid];
    last          = req_last[gid];
    sram_write_en = xfer & we;
    sram_read_en  = xfer & ~we;
    sram_addr     = xfer ? req_addr[int'(gid)*SRAM_DEPTH_BIT +: SRAM_DEPTH_BIT] : '0;
    sram_data_in  = xfer ? req_wdata[int'(gid)*SRAM_WIDTH +: SRAM_WIDTH] : '0;
    cnt_inc       = (state == LOCK ? beat_cnt : '0) + CW'(1);
    rel           = last || cnt_inc == CW'(MAX_BURST);
    ptr_inc       = gid == IW'(NUM_REQ - 1) ? '0 : gid + IW'(1);
    state_nxt     = xfer ? (rel ? IDLE : LOCK) : state;
    owner_nxt     = xfer ? gid : owner;
    ptr_nxt       = xfer && rel ? ptr_inc : rr_ptr;
    cnt_nxt       = xfer ? (rel ? '0 : cnt_inc) : beat_cnt;
    rsp_valid     = rsp_pend && !rst ? NUM_REQ'(1) << rsp_id : '0;
    rsp_data      = rst ? '0 : sram_data_out;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      rsp_pend <= 1'b0;
      rsp_id   <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= ptr_nxt;
      beat_cnt <= cnt_nxt;
      rsp_pend <= sram_read_en;
      rsp_id   <= gid;
    end
  end
endmodule

// File: tb/tb_sram_rr_arbiter.sv
// tb_sram_rr_arbiter: directed and random traffic against a spec-level arbiter/memory model with per-cycle comparison
module tb_sram_rr_arbiter;
  localparam int NR = 4;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int MB = 16;
  typedef struct {
    bit          we;
    bit          last;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } beat_t;
  logic clk = 0;
  logic rst;
  logic [NR-1:0] req_valid, req_ready, req_we, req_last, rsp_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0] rsp_data, sram_data_in, sram_data_out;
  logic sram_read_en, sram_write_en;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] m_mem [1<<AW];
  bit m_lock = 0;
  int m_owner = 0, m_cnt = 0, m_ptr = 0, m_rsp_id = 0;
  bit m_rsp_pend = 0;
  logic [DW-1:0] m_rsp_data = '0;
  beat_t qs [NR][$];
  int glog [$];
  int wt [NR];
  int max_wait = 0;
  int vectors = 0, errs = 0;
  sram_rr_arbiter #(.NUM_REQ(NR), .SRAM_DEPTH_BIT(AW), .SRAM_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_last(req_last), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .sram_read_en(sram_read_en), .sram_write_en(sram_write_en),
    .sram_addr(sram_addr), .sram_data_in(sram_data_in), .sram_data_out(sram_data_out)
  );
  always #5 clk = ~clk;
  initial for (int i = 0; i < (1 << AW); i++) begin
    mem[i] = '0;
    m_mem[i] = '0;
  end
  always @(posedge clk) begin
    if (sram_write_en) mem[sram_addr] <= sram_data_in;
    if (sram_read_en) sram_data_out <= mem[sram_addr];
  end
  function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endfunction
  function automatic int exp_grant();
    if (rst) return -1;
    if (m_lock) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < NR; k++) if (req_valid[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    return -1;
  endfunction
  always @(posedge clk) begin
    int g, gg, cnt;
    g = exp_grant();
    gg = g < 0 ? 0 : g;
    if (rst) begin
      m_lock <= 0; m_owner <= 0; m_cnt <= 0; m_ptr <= 0; m_rsp_pend <= 0;
    end else begin
      m_rsp_pend <= g >= 0 && !req_we[gg];
      m_rsp_id <= gg;
      m_rsp_data <= m_mem[req_addr[gg*AW +: AW]];
      if (g >= 0) begin
        if (req_we[g]) m_mem[req_addr[g*AW +: AW]] <= req_wdata[g*DW +: DW];
        cnt = (m_lock ? m_cnt : 0) + 1;
        if (req_last[g] || cnt == MB) begin
          m_lock <= 0; m_cnt <= 0; m_ptr <= (g + 1) % NR;
        end else begin
          m_lock <= 1; m_cnt <= cnt; m_owner <= g;
        end
      end
    end
  end
  always @(negedge clk) begin
    int g, gg;
    g = exp_grant();
    gg = g < 0 ? 0 : g;
    chk("ready", req_ready, g < 0 ? 0 : 1 << g);
    chk("write_en", sram_write_en, g >= 0 && req_we[gg]);
    chk("read_en", sram_read_en, g >= 0 && !req_we[gg]);
    chk("addr", sram_addr, g >= 0 ? req_addr[gg*AW +: AW] : 0);
    chk("data_in", sram_data_in, g >= 0 ? req_wdata[gg*DW +: DW] : 0);
    chk("one_enable", sram_read_en & sram_write_en, 0);
    chk("rsp_valid", rsp_valid, m_rsp_pend && !rst ? 1 << m_rsp_id : 0);
    if (m_rsp_pend && !rst) chk("rsp_data", rsp_data, m_rsp_data);
    if (rst) chk("rsp_data_rst", rsp_data, 0);
  end
  task automatic drive();
    beat_t b;
    for (int i = 0; i < NR; i++) begin
      b = '{0, 0, '0, '0};
      if (qs[i].size() > 0) b = qs[i][0];
      req_valid[i] = qs[i].size() > 0;
      req_we[i] = b.we;
      req_last[i] = b.last;
      req_addr[i*AW +: AW] = b.addr;
      req_wdata[i*DW +: DW] = b.data;
    end
  endtask
  function automatic bit busy();
    for (int i = 0; i < NR; i++) if (qs[i].size() > 0) return 1;
    return 0;
  endfunction
  task automatic push(input int i, input bit we, input bit last, input int a, input logic [DW-1:0] d);
    qs[i].push_back('{we, last, AW'(a), d});
  endtask
  task automatic push_burst(input int i, input int n, input bit we, input int a);
    for (int k = 0; k < n; k++) push(i, we, k == n - 1, a + k, DW'(a + k));
  endtask
  task automatic run(input int ncyc);
    int c;
    logic [NR-1:0] acc;
    c = 0;
    drive();
    while (ncyc == 0 ? busy() : c < ncyc) begin
      if (c == 3000) begin
        vectors++; errs++;
        $display("FAIL run_timeout: still busy after %0d cycles, required drain", c);
        break;
      end
      @(negedge clk);
      acc = req_valid & req_ready;
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) glog.push_back(i);
        wt[i] = req_valid[i] && !acc[i] ? wt[i] + 1 : 0;
        if (wt[i] > max_wait) max_wait = wt[i];
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) if (acc[i]) void'(qs[i].pop_front());
      drive();
      c++;
    end
  endtask
  task automatic do_reset();
    rst = 1;
    for (int i = 0; i < NR; i++) qs[i].delete();
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 0;
    glog.delete();
  endtask
  function automatic int lg(input int k);
    return glog.size() > k ? glog[k] : -1;
  endfunction
  initial begin
    rst = 1;
    req_valid = '1;
    req_we = '0;
    req_last = '1;
    req_addr = '0;
    req_wdata = '0;
    for (int i = 0; i < NR; i++) wt[i] = 0;
    @(negedge clk);
    chk("reset_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    @(posedge clk);
    #1;
    do_reset();
    for (int r = 0; r < 2; r++) for (int i = 0; i < NR; i++) push(i, 0, 1, i, '0);
    run(0);
    for (int k = 0; k < 8; k++) chk($sformatf("t1_grant%0d", k), lg(k), k % 4);
    @(negedge clk);
    chk("t1_rsp_lag", rsp_valid, 4'b1000);
    @(posedge clk);
    #1;
    push(1, 1, 1, 5, 64'hA5A5);
    push(1, 0, 1, 5, '0);
    run(0);
    @(negedge clk);
    chk("t2_rsp_valid", rsp_valid, 4'b0010);
    chk("t2_rsp_data", rsp_data, 64'hA5A5);
    @(posedge clk);
    #1;
    do_reset();
    push_burst(2, 4, 0, 100);
    run(1);
    push(0, 0, 1, 7, '0);
    run(3);
    chk("t3_model_ptr", m_ptr, 3);
    run(0);
    chk("t3_len", glog.size(), 5);
    chk("t3_beat4", lg(3), 2);
    chk("t3_req0", lg(4), 0);
    do_reset();
    push_burst(3, 40, 0, 200);
    run(1);
    for (int i = 0; i < 3; i++) push(i, 0, 1, 300 + i, '0);
    run(0);
    chk("t4_len", glog.size(), 43);
    chk("t4_beat16", lg(15), 3);
    chk("t4_rel0", lg(16), 0);
    chk("t4_rel1", lg(17), 1);
    chk("t4_rel2", lg(18), 2);
    chk("t4_resume", lg(19), 3);
    chk("t4_end", lg(42), 3);
    do_reset();
    push_burst(2, 6, 0, 400);
    run(3);
    rst = 1;
    @(negedge clk);
    chk("t5_rsp_in_rst", rsp_valid, 0);
    chk("t5_ready_in_rst", req_ready, 0);
    @(posedge clk);
    #1;
    rst = 0;
    for (int i = 0; i < NR; i++) qs[i].delete();
    drive();
    @(negedge clk);
    chk("t5_rsp_after_rst", rsp_valid, 0);
    @(posedge clk);
    #1;
    glog.delete();
    push(3, 0, 1, 9, '0);
    push(1, 0, 1, 8, '0);
    run(0);
    chk("t5_first", lg(0), 1);
    chk("t5_second", lg(1), 3);
    do_reset();
    max_wait = 0;
    for (int i = 0; i < NR; i++) begin
      for (int b = 0; b < 6; b++) begin
        int n;
        n = $urandom_range(1, 20);
        for (int k = 0; k < n; k++) push(i, 1'($urandom), k == n - 1, $urandom_range(0, 15), {$urandom, $urandom});
      end
    end
    run(0);
    vectors++;
    if (max_wait > (NR - 1) * MB) begin
      errs++;
      $display("FAIL t6_max_wait: got %0d expected at most %0d", max_wait, (NR - 1) * MB);
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
